// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory request/response, redirect from
// execute, and the decode-side instruction handshake.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instruction, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches, buffers
// returned words with their PC and hands them to decode; redirect flushes all.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input logic        clk,
    input logic        rst,
    fetch_unit_if.master bus
);
    localparam int          CW  = $clog2(FIFO_DEPTH + 1);
    localparam int          IW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   pc;
    logic [31:0]   fifo_pc   [FIFO_DEPTH];
    logic [31:0]   fifo_word [FIFO_DEPTH];
    logic [IW-1:0] head;
    logic [IW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] pending;
    logic [CW-1:0] drop;

    logic          redirect;
    logic          req_fire;
    logic          push;
    logic          pop;
    logic [CW-1:0] live_inflight;
    logic [31:0]   rsp_pc;
    logic [31:0]   redirect_target;

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
        return (p == IW'(FIFO_DEPTH - 1)) ? '0 : p + IW'(1);
    endfunction

    // Non-stale requests since the last redirect are contiguous, so the oldest
    // live one sits (pending - drop) words behind the current PC.
    // A word leaving to decode this cycle frees its slot for a new request,
    // which keeps a 1-cycle memory streaming one word per cycle.
    always_comb begin
        redirect           = bus.redirect_valid;
        redirect_target    = bus.redirect_pc & 32'hFFFF_FFFC;
        live_inflight      = pending - drop;
        rsp_pc             = pc - {{(30 - CW){1'b0}}, live_inflight, 2'b00};
        bus.instr_valid    = !rst && (count != '0);
        bus.instruction    = (count != '0) ? fifo_word[head] : NOP;
        bus.instr_pc       = (count != '0) ? fifo_pc[head] : 32'h0;
        pop                = bus.instr_valid && bus.instr_ready && !redirect;
        bus.imem_req_valid = !rst && !redirect &&
                             ((int'(count) + int'(pending) - int'(pop)) < FIFO_DEPTH);
        bus.imem_req_addr  = pc;
        req_fire           = bus.imem_req_valid && bus.imem_req_ready;
        push               = bus.imem_rsp_valid && !redirect && (drop == '0);
    end

    // Control state; a redirect turns every response still in flight stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            pending <= '0;
            drop    <= '0;
        end else begin
            pending <= pending + CW'(req_fire) - CW'(bus.imem_rsp_valid);
            if (redirect) begin
                pc    <= redirect_target;
                head  <= '0;
                tail  <= '0;
                count <= '0;
                drop  <= pending - CW'(bus.imem_rsp_valid);
            end else begin
                if (req_fire)
                    pc <= pc + 32'd4;
                if (bus.imem_rsp_valid && (drop != '0))
                    drop <= drop - CW'(1);
                if (push)
                    tail <= next_ptr(tail);
                if (pop)
                    head <= next_ptr(head);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_pc[tail]   <= rsp_pc;
            fifo_word[tail] <= bus.imem_rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && bus.imem_rsp_valid)
            rsp_without_request: assert (pending != '0);
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model with adjustable latency and
// stall, directed phases for streaming, backpressure, redirect and reset.
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    logic clk = 1'b0;
    logic rst;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t        exp_q [$];
    mreq_t       mem_q [$];
    exp_t        mon_e;
    mreq_t       mem_r;
    int          n_compared   = 0;
    int          n_mismatched = 0;
    int          delivered    = 0;
    int          cyc          = 0;
    int          mem_lat      = 1;
    int          outstanding  = 0;
    int          accept_count = 0;
    logic [31:0] fetch_base   = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic r, input logic mem_ready, input logic dec_ready,
                                  input logic rv, input logic [31:0] rpc);
        rst                = r;
        bus.imem_req_ready = mem_ready;
        bus.instr_ready    = dec_ready;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
    endtask

    task automatic start_stream(input logic [31:0] base);
        exp_t e;
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            e.pc   = base + 32'(4 * i);
            e.word = mem_word(e.pc);
            exp_q.push_back(e);
        end
        fetch_base   = base;
        accept_count = 0;
    endtask

    task automatic wait_deliveries(input string name, input int n, input int budget);
        int start;
        int k;
        start = delivered;
        k     = 0;
        while ((delivered - start) < n && k < budget) begin
            tick();
            k++;
        end
        check_output(name, ((delivered - start) >= n) ? 32'(n) : 32'(delivered - start), 32'(n));
    endtask

    task automatic measure_latency(input string name, input int expected);
        int k;
        k = 1;
        @(negedge clk);
        while (!bus.instr_valid && k < 12) begin
            tick();
            k++;
            @(negedge clk);
        end
        check_output(name, 32'(k), 32'(expected));
    endtask

    // Memory model: fixed per-request latency chosen at acceptance, in order,
    // reset together with the fetch unit.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mem_q.delete();
            outstanding = 0;
            bus.imem_rsp_valid <= 1'b0;
            bus.imem_rsp_data  <= 32'h0;
        end else begin
            if (bus.imem_rsp_valid)
                outstanding--;
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                mem_r.addr = bus.imem_req_addr;
                mem_r.due  = cyc + mem_lat - 1;
                mem_q.push_back(mem_r);
                outstanding++;
                accept_count++;
            end
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                mem_r = mem_q.pop_front();
                bus.imem_rsp_valid <= 1'b1;
                bus.imem_rsp_data  <= mem_word(mem_r.addr);
            end else begin
                bus.imem_rsp_valid <= 1'b0;
            end
        end
    end

    // Monitor: every accepted decode handshake is matched against the queue.
    always @(negedge clk) begin
        if (!rst && !bus.redirect_valid && bus.instr_valid && bus.instr_ready) begin
            delivered++;
            if (exp_q.size() == 0) begin
                n_compared++;
                n_mismatched++;
                $display("[TB] FAIL sb_underflow: got pc 0x%08h expected no delivery", bus.instr_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("instr_pc", bus.instr_pc, mon_e.pc);
                check_output("instruction", bus.instruction, mon_e.word);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int k;

        mem_lat = 1;
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        @(negedge clk);
        check_output("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        check_output("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check_output("rst_instruction", bus.instruction, NOP);
        check_output("rst_instr_pc", bus.instr_pc, 32'h0);
        tick();

        // Free-run from RESET_PC with a 1-cycle memory.
        start_stream(32'h0);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check_output("post_rst_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check_output("post_rst_req_addr", bus.imem_req_addr, 32'h0);
        wait_deliveries("t1_first_word", 1, 10);
        k = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.instr_valid && bus.instr_ready)
                k++;
        end
        check_output("t1_zero_bubble", 32'(k), 32'd16);

        // Decode backpressure: buffer fills and requests stop.
        tick();
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (10) tick();
        @(negedge clk);
        check_output("t2_req_valid_full", 32'(bus.imem_req_valid), 32'd0);
        check_output("t2_instr_valid", 32'(bus.instr_valid), 32'd1);
        check_output("t2_req_addr", bus.imem_req_addr, fetch_base + 32'(4 * accept_count));
        tick();
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        wait_deliveries("t2_resume", 10, 20);

        // Redirect with two requests in flight on a 3-cycle memory.
        mem_lat = 3;
        k = 0;
        while (outstanding != 2 && k < 20) begin
            tick();
            k++;
        end
        check_output("t3_pending_two", 32'(outstanding), 32'd2);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
        start_stream(32'h0000_0100);
        tick();
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        wait_deliveries("t3_after_redirect", 6, 40);

        // Memory stall: PC holds, buffer drains to the NOP idle value.
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check_output("t5_addr_start", bus.imem_req_addr, fetch_base + 32'(4 * accept_count));
        repeat (5) tick();
        @(negedge clk);
        check_output("t5_addr_end", bus.imem_req_addr, fetch_base + 32'(4 * accept_count));
        check_output("t5_instr_valid", 32'(bus.instr_valid), 32'd0);
        check_output("t5_nop", bus.instruction, NOP);
        check_output("t5_pc_zero", bus.instr_pc, 32'h0);
        mem_lat = 1;
        tick();
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        wait_deliveries("t5_resume", 6, 20);

        // Misaligned redirect coinciding with a decode handshake.
        k = 0;
        while (!bus.instr_valid && k < 10) begin
            tick();
            k++;
        end
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0203);
        start_stream(32'h0000_0200);
        tick();
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        measure_latency("t4_latency", 3);
        wait_deliveries("t4_stream", 4, 20);

        // Back-to-back redirects: the second target wins.
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0300);
        tick();
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0404);
        start_stream(32'h0000_0404);
        tick();
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        measure_latency("t4b_latency", 3);
        wait_deliveries("t4b_stream", 4, 20);

        // Reset mid-stream with buffered and in-flight words.
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        k = 0;
        while (!(bus.instr_valid && outstanding == 1) && k < 10) begin
            tick();
            k++;
        end
        check_output("t6_setup_outstanding", 32'(outstanding), 32'd1);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        exp_q.delete();
        @(negedge clk);
        check_output("t6_rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        check_output("t6_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        tick();
        start_stream(32'h0);
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        @(negedge clk);
        check_output("t6_restart_instr_valid", 32'(bus.instr_valid), 32'd0);
        check_output("t6_restart_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check_output("t6_restart_addr", bus.imem_req_addr, 32'h0);
        wait_deliveries("t6_stream", 8, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
